// File: rtl/audio_sram_arbiter_if.sv
// Requester handshakes and SRAM pin bundle between the audio recorder/player and the arbiter.
// The arbiter connects through the slave modport; the surrounding logic uses master.
interface audio_sram_arbiter_if;
  logic        i_rec_req;
  logic [19:0] i_rec_addr;
  logic [15:0] i_rec_data;
  logic        o_rec_ack;
  logic        i_play_req;
  logic [19:0] i_play_addr;
  logic [15:0] o_play_data;
  logic        o_play_valid;
  logic        i_clear_len;
  logic [20:0] o_rec_len;
  logic [19:0] o_sram_addr;
  logic [15:0] o_sram_dq;
  logic        o_sram_dq_oe;
  logic [15:0] i_sram_dq;
  logic        o_sram_we_n;
  logic        o_sram_oe_n;
  logic        o_sram_ce_n;
  logic        o_sram_lb_n;
  logic        o_sram_ub_n;

  modport slave (
    input  i_rec_req, i_rec_addr, i_rec_data, i_play_req, i_play_addr,
           i_clear_len, i_sram_dq,
    output o_rec_ack, o_play_data, o_play_valid, o_rec_len, o_sram_addr,
           o_sram_dq, o_sram_dq_oe, o_sram_we_n, o_sram_oe_n, o_sram_ce_n,
           o_sram_lb_n, o_sram_ub_n
  );

  modport master (
    output i_rec_req, i_rec_addr, i_rec_data, i_play_req, i_play_addr,
           i_clear_len, i_sram_dq,
    input  o_rec_ack, o_play_data, o_play_valid, o_rec_len, o_sram_addr,
           o_sram_dq, o_sram_dq_oe, o_sram_we_n, o_sram_oe_n, o_sram_ce_n,
           o_sram_lb_n, o_sram_ub_n
  );
endinterface

// File: rtl/audio_sram_arbiter.sv
// Round-robin arbiter sharing one 1M x 16 SRAM between the recorder (writes) and the
// player (reads); sequences the SRAM strobes and tracks the recorded length.
module audio_sram_arbiter #(
  parameter int WR_PULSE = 2,
  parameter int RD_WAIT  = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  audio_sram_arbiter_if.slave  bus
);

  localparam int CNT_MAX = (WR_PULSE > RD_WAIT) ? WR_PULSE : RD_WAIT;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t WR_LOAD = cnt_t'(WR_PULSE - 1);
  localparam cnt_t RD_LOAD = cnt_t'(RD_WAIT - 1);

  typedef enum logic [2:0] {
    IDLE, W_SETUP, W_PULSE, W_HOLD, R_WAIT, R_DONE
  } state_t;

  typedef enum logic {GNT_REC, GNT_PLAY} grant_t;

  state_t      state, state_d;
  cnt_t        cnt, cnt_d;
  grant_t      last_grant;
  logic        grant_rec, grant_play;
  logic [20:0] addr_p1;

  // Widened before the increment so address 0xFFFFF yields 0x100000.
  assign addr_p1 = {1'b0, bus.o_sram_addr} + 21'd1;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge value of the others, independent of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    grant_rec  = 1'b0;
    grant_play = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.i_rec_req && (!bus.i_play_req || last_grant == GNT_PLAY)) begin
          grant_rec = 1'b1;
          state_d   = W_SETUP;
        end else if (bus.i_play_req) begin
          grant_play = 1'b1;
          state_d    = R_WAIT;
          cnt_d      = RD_LOAD;
        end
      end
      W_SETUP: begin
        state_d = W_PULSE;
        cnt_d   = WR_LOAD;
      end
      W_PULSE: begin
        if (cnt == '0) state_d = W_HOLD;
        else           cnt_d   = cnt - 1'b1;
      end
      W_HOLD: state_d = IDLE;
      R_WAIT: begin
        if (cnt == '0) state_d = R_DONE;
        else           cnt_d   = cnt - 1'b1;
      end
      R_DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they line up with
  // the state they belong to without any combinational path to the pins.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      last_grant       <= GNT_PLAY;
      bus.o_rec_ack    <= 1'b0;
      bus.o_play_valid <= 1'b0;
      bus.o_play_data  <= '0;
      bus.o_rec_len    <= '0;
      bus.o_sram_addr  <= '0;
      bus.o_sram_dq    <= '0;
      bus.o_sram_dq_oe <= 1'b0;
      bus.o_sram_we_n  <= 1'b1;
      bus.o_sram_oe_n  <= 1'b1;
      bus.o_sram_ce_n  <= 1'b1;
      bus.o_sram_lb_n  <= 1'b1;
      bus.o_sram_ub_n  <= 1'b1;
    end else begin
      bus.o_sram_ce_n  <= 1'b0;
      bus.o_sram_lb_n  <= 1'b0;
      bus.o_sram_ub_n  <= 1'b0;
      bus.o_sram_we_n  <= (state_d != W_PULSE);
      bus.o_sram_oe_n  <= (state_d != R_WAIT);
      bus.o_sram_dq_oe <= (state_d inside {W_SETUP, W_PULSE, W_HOLD});
      bus.o_rec_ack    <= (state_d == W_HOLD);
      bus.o_play_valid <= (state_d == R_DONE);

      if (grant_rec) begin
        last_grant      <= GNT_REC;
        bus.o_sram_addr <= bus.i_rec_addr;
        bus.o_sram_dq   <= bus.i_rec_data;
      end else if (grant_play) begin
        last_grant      <= GNT_PLAY;
        bus.o_sram_addr <= bus.i_play_addr;
      end

      if (state == R_WAIT && cnt == '0) bus.o_play_data <= bus.i_sram_dq;

      // Clear takes priority over a coinciding length update.
      if (bus.i_clear_len)                               bus.o_rec_len <= '0;
      else if (state == W_HOLD && addr_p1 > bus.o_rec_len) bus.o_rec_len <= addr_p1;
    end
  end

endmodule

// File: tb/tb_audio_sram_arbiter.sv
// Directed bench for audio_sram_arbiter: vector table for single accesses plus
// hand sequences for arbitration, mid-access reset and parameter sweeps.
module tb_audio_sram_arbiter;

  logic i_clk = 1'b0;
  logic i_rst;
  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  audio_sram_arbiter_if ab ();
  audio_sram_arbiter #(.WR_PULSE(2), .RD_WAIT(2)) u_dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (ab.slave)
  );

  // Small SRAM model: 256 words, indexed by the low address byte.
  logic [15:0] mem [256];
  always @(posedge i_clk) if (!ab.o_sram_we_n) mem[ab.o_sram_addr[7:0]] <= ab.o_sram_dq;
  assign ab.i_sram_dq = ab.o_sram_oe_n ? 16'h0000 : mem[ab.o_sram_addr[7:0]];

  // Sweep instances: [0] WR_PULSE=1/RD_WAIT=1, [1] WR_PULSE=4/RD_WAIT=3; SRAM echoes the address.
  logic        sw_rec_req  [2];
  logic        sw_play_req [2];
  logic        sw_ack      [2];
  logic        sw_valid    [2];
  logic [15:0] sw_data     [2];

  for (genvar g = 0; g < 2; g++) begin : g_sweep
    audio_sram_arbiter_if sb ();
    audio_sram_arbiter #(.WR_PULSE(g == 0 ? 1 : 4), .RD_WAIT(g == 0 ? 1 : 3)) u_sw (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .bus   (sb.slave)
    );
    assign sb.i_rec_req   = sw_rec_req[g];
    assign sb.i_rec_addr  = 20'h00ABC;
    assign sb.i_rec_data  = 16'h1111;
    assign sb.i_play_req  = sw_play_req[g];
    assign sb.i_play_addr = 20'h00ABC;
    assign sb.i_clear_len = 1'b0;
    assign sb.i_sram_dq   = sb.o_sram_oe_n ? 16'h0000 : sb.o_sram_addr[15:0];
    assign sw_ack[g]      = sb.o_rec_ack;
    assign sw_valid[g]    = sb.o_play_valid;
    assign sw_data[g]     = sb.o_play_data;
  end

  typedef struct {
    logic        wr;
    logic [19:0] addr;
    logic [15:0] data;
    logic        clr_req;   // clear asserted together with the request
    logic        clr_hold;  // clear asserted during the ack (W_HOLD) cycle
    int          lat;
    logic [15:0] we_tr;     // bit i = we_n seen in cycle i after the grant cycle
    logic [15:0] oe_tr;
    logic [15:0] dqoe_tr;
    logic [15:0] rdata;
    logic [20:0] len;       // o_rec_len in the IDLE cycle after completion
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t wv(input logic [19:0] a, input logic [15:0] d,
                              input logic cr, input logic ch, input logic [20:0] len);
    return '{1'b1, a, d, cr, ch, 4, 16'h0012, 16'h001E, 16'h001E, 16'h0000, len};
  endfunction

  function automatic vec_t rv(input logic [19:0] a, input logic [15:0] d,
                              input logic [20:0] len);
    return '{1'b0, a, 16'h0000, 1'b0, 1'b0, 3, 16'h000E, 16'h0008, 16'h0000, d, len};
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge of the following IDLE cycle.
  task automatic apply_vec(input vec_t v, input string tag);
    logic [15:0] we_tr, oe_tr, dq_tr;
    int lat;
    lat = 0; we_tr = '0; oe_tr = '0; dq_tr = '0;
    if (v.wr) begin
      ab.i_rec_req  = 1'b1;
      ab.i_rec_addr = v.addr;
      ab.i_rec_data = v.data;
    end else begin
      ab.i_play_req  = 1'b1;
      ab.i_play_addr = v.addr;
    end
    ab.i_clear_len = v.clr_req;
    for (int i = 1; i <= 15; i++) begin
      @(negedge i_clk);
      ab.i_clear_len = 1'b0;
      we_tr[i] = ab.o_sram_we_n;
      oe_tr[i] = ab.o_sram_oe_n;
      dq_tr[i] = ab.o_sram_dq_oe;
      if (v.wr ? ab.o_rec_ack : ab.o_play_valid) begin
        lat = i;
        break;
      end
    end
    check({tag, " latency"}, lat, v.lat);
    check({tag, " we_n trace"}, we_tr, v.we_tr);
    check({tag, " oe_n trace"}, oe_tr, v.oe_tr);
    check({tag, " dq_oe trace"}, dq_tr, v.dqoe_tr);
    if (!v.wr) check({tag, " read data"}, ab.o_play_data, v.rdata);
    ab.i_rec_req   = 1'b0;
    ab.i_play_req  = 1'b0;
    ab.i_clear_len = v.clr_hold;
    @(negedge i_clk);
    ab.i_clear_len = 1'b0;
    check({tag, " idle dq_oe"}, ab.o_sram_dq_oe, 1'b0);
    check({tag, " single pulse"}, ab.o_rec_ack | ab.o_play_valid, 1'b0);
    check({tag, " rec_len"}, ab.o_rec_len, v.len);
  endtask

  task automatic sweep(input int g, input int wr_lat, input int rd_lat);
    int lat;
    lat = 0;
    sw_rec_req[g] = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge i_clk);
      if (sw_ack[g]) begin lat = i; break; end
    end
    sw_rec_req[g] = 1'b0;
    check($sformatf("sweep%0d write latency", g), lat, wr_lat);
    @(negedge i_clk);
    lat = 0;
    sw_play_req[g] = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge i_clk);
      if (sw_valid[g]) begin lat = i; break; end
    end
    sw_play_req[g] = 1'b0;
    check($sformatf("sweep%0d read latency", g), lat, rd_lat);
    check($sformatf("sweep%0d read data", g), sw_data[g], 16'h0ABC);
    @(negedge i_clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [10];
    int   ev_cyc [4];
    logic ev_rec [4];
    int   nev, acks;

    vecs[0] = wv(20'h00010, 16'hBEEF, 1'b0, 1'b0, 21'h000011);
    vecs[1] = rv(20'h00010, 16'hBEEF, 21'h000011);
    vecs[2] = wv(20'h00005, 16'h1234, 1'b1, 1'b0, 21'h000006);
    vecs[3] = wv(20'h00002, 16'h5678, 1'b0, 1'b0, 21'h000006);
    vecs[4] = rv(20'h00005, 16'h1234, 21'h000006);
    vecs[5] = wv(20'hFFFFF, 16'hA5A5, 1'b0, 1'b0, 21'h100000);
    vecs[6] = wv(20'h00003, 16'h0F0F, 1'b1, 1'b0, 21'h000004);
    vecs[7] = wv(20'hFFFFF, 16'h3C3C, 1'b0, 1'b1, 21'h000000);
    vecs[8] = rv(20'h00002, 16'h5678, 21'h000000);
    vecs[9] = rv(20'hFFFFF, 16'h3C3C, 21'h000000);

    ab.i_rec_req = 1'b0; ab.i_rec_addr = '0; ab.i_rec_data = '0;
    ab.i_play_req = 1'b0; ab.i_play_addr = '0; ab.i_clear_len = 1'b0;
    for (int g = 0; g < 2; g++) begin sw_rec_req[g] = 1'b0; sw_play_req[g] = 1'b0; end

    // Reset values
    i_rst = 1'b1;
    @(negedge i_clk); @(negedge i_clk);
    check("rst rec_ack",    ab.o_rec_ack,    1'b0);
    check("rst play_valid", ab.o_play_valid, 1'b0);
    check("rst play_data",  ab.o_play_data,  16'h0000);
    check("rst rec_len",    ab.o_rec_len,    21'h0);
    check("rst sram_addr",  ab.o_sram_addr,  20'h0);
    check("rst sram_dq",    ab.o_sram_dq,    16'h0);
    check("rst dq_oe",      ab.o_sram_dq_oe, 1'b0);
    check("rst strobes",    {ab.o_sram_we_n, ab.o_sram_oe_n, ab.o_sram_ce_n,
                             ab.o_sram_lb_n, ab.o_sram_ub_n}, 5'b11111);
    i_rst = 1'b0;
    @(negedge i_clk);
    check("run ce/lb/ub", {ab.o_sram_ce_n, ab.o_sram_lb_n, ab.o_sram_ub_n}, 3'b000);
    check("run we/oe", {ab.o_sram_we_n, ab.o_sram_oe_n}, 2'b11);

    // Single accesses, length tracking and clear
    for (int i = 0; i < 10; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

    // Both requesters busy from reset: grants must alternate rec, play, rec, play
    i_rst = 1'b1;
    ab.i_rec_addr = 20'h00040; ab.i_rec_data = 16'h4444; ab.i_play_addr = 20'h00040;
    ab.i_rec_req = 1'b1; ab.i_play_req = 1'b1;
    @(negedge i_clk); @(negedge i_clk);
    i_rst = 1'b0;
    nev = 0;
    for (int k = 0; k < 4; k++) begin ev_cyc[k] = 0; ev_rec[k] = 1'b0; end
    for (int c = 1; c <= 40 && nev < 4; c++) begin
      @(negedge i_clk);
      if (ab.o_rec_ack) begin
        if (nev < 4) begin ev_cyc[nev] = c; ev_rec[nev] = 1'b1; nev++; end
        ab.i_rec_req = 1'b0;
      end else ab.i_rec_req = 1'b1;
      if (ab.o_play_valid) begin
        if (nev < 4) begin ev_cyc[nev] = c; ev_rec[nev] = 1'b0; nev++; end
        ab.i_play_req = 1'b0;
      end else ab.i_play_req = 1'b1;
    end
    ab.i_rec_req = 1'b0; ab.i_play_req = 1'b0;
    check("alt event count", nev, 4);
    check("alt order", {ev_rec[0], ev_rec[1], ev_rec[2], ev_rec[3]}, 4'b1010);
    check("alt first ack cycle", ev_cyc[0], 4);
    check("alt gap rec->play", ev_cyc[1] - ev_cyc[0], 4);
    check("alt gap play->rec", ev_cyc[2] - ev_cyc[1], 5);
    check("alt gap rec->play 2", ev_cyc[3] - ev_cyc[2], 4);
    check("alt read data", ab.o_play_data, 16'h4444);
    @(negedge i_clk); @(negedge i_clk);

    // Reset in the middle of the write pulse
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    ab.i_rec_req = 1'b1; ab.i_rec_addr = 20'h00020; ab.i_rec_data = 16'h7777;
    @(negedge i_clk); @(negedge i_clk);
    check("midrst we_n low in pulse", ab.o_sram_we_n, 1'b0);
    i_rst = 1'b1;
    @(negedge i_clk);
    check("midrst we_n", ab.o_sram_we_n, 1'b1);
    check("midrst dq_oe", ab.o_sram_dq_oe, 1'b0);
    check("midrst rec_ack", ab.o_rec_ack, 1'b0);
    i_rst = 1'b0;
    ab.i_rec_req = 1'b0;
    acks = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge i_clk);
      if (ab.o_rec_ack) acks++;
    end
    check("midrst no ack", acks, 0);
    apply_vec(wv(20'h00020, 16'h7777, 1'b0, 1'b0, 21'h000021), "post-rst write");
    apply_vec(rv(20'h00020, 16'h7777, 21'h000021), "post-rst read");

    // Parameter sweeps
    sweep(0, 3, 2);
    sweep(1, 6, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/audio_sram_arbiter.md
Name: audio_sram_arbiter

Overview:
Shares the single 1M x 16 off-chip SRAM between the audio recorder and the audio player. The recorder is the write requester and the player is the read requester. The block arbitrates between them round-robin and sequences the SRAM strobes for each access. It also tracks the recorded length, so the player knows where valid audio ends. It sits between the recorder/player and the top-level SRAM pins; the top level owns the DQ tristate.

Parameters:
WR_PULSE, 2, cycles o_sram_we_n is held low per write (>=1)
RD_WAIT, 2, cycles o_sram_oe_n is held low before read data is captured (>=1)

Ports:
i_clk  in  1  system clock; the single clock for the block and both requesters
i_rst  in  1  synchronous active-high reset
i_rec_req  in  1  recorder write request, level
i_rec_addr  in  20  write address
i_rec_data  in  16  write data
o_rec_ack  out  1  one-cycle write-done pulse
i_play_req  in  1  player read request, level
i_play_addr  in  20  read address
o_play_data  out  16  read data, valid while o_play_valid=1
o_play_valid  out  1  one-cycle read-done pulse
i_clear_len  in  1  clear recorded length
o_rec_len  out  21  one plus the highest address written since clear
o_sram_addr  out  20  SRAM address
o_sram_dq  out  16  SRAM write data
o_sram_dq_oe  out  1  1 = top level drives DQ
i_sram_dq  in  16  SRAM read data
o_sram_we_n, o_sram_oe_n, o_sram_ce_n, o_sram_lb_n, o_sram_ub_n  out  1 each  SRAM strobes, active low

Behaviour:
- Reset values (i_rst sampled high on a rising edge):
  - FSM goes to IDLE.
  - o_rec_ack=0, o_play_valid=0, o_play_data=0, o_rec_len=0.
  - o_sram_addr=0, o_sram_dq=0, o_sram_dq_oe=0.
  - we_n, oe_n, ce_n, lb_n, ub_n all =1.
  - last_grant = player.
- Outside reset, ce_n, lb_n and ub_n are 0 constantly.
- All outputs are registered.
- Reset mid-access aborts immediately; the access is lost, and no ack or valid is issued.
- FSM states: IDLE, W_SETUP, W_PULSE, W_HOLD, R_WAIT, R_DONE.
- Request sampling:
  - Requests are sampled only in IDLE.
  - A requester holds req, addr and data stable until its ack/valid.
  - A requester must drive req low in the cycle after its ack/valid.
- Arbitration in IDLE:
  - Only one req high: grant that requester.
  - Both high: grant the requester that is not last_grant.
  - last_grant is updated on every grant.
  - The granted addr and data are latched into o_sram_addr and o_sram_dq at the grant edge.
- Write sequence:
  - IDLE -> W_SETUP, 1 cycle: dq_oe=1, we_n=1.
  - W_PULSE, WR_PULSE cycles: we_n=0.
  - W_HOLD, 1 cycle: we_n=1, dq_oe=1, o_rec_ack=1.
  - Then IDLE, with dq_oe=0.
  - Ack arrives WR_PULSE+2 cycles after the grant cycle.
- Read sequence:
  - IDLE -> R_WAIT, RD_WAIT cycles: oe_n=0, dq_oe=0.
  - i_sram_dq is captured into o_play_data on the last R_WAIT edge.
  - R_DONE, 1 cycle: oe_n=1, o_play_valid=1.
  - Then IDLE.
  - o_play_data holds its value until the next read completes.
- Turnaround: dq_oe and oe_n are never both active in the same cycle. Every access returns through one IDLE cycle.
- Length tracking:
  - In W_HOLD: if addr+1 > o_rec_len, then o_rec_len <= addr+1.
  - The addition uses 21 bits, so address 0xFFFFF gives 0x100000 with no wrap.
- Clear:
  - i_clear_len sets o_rec_len to 0 on the next edge.
  - It does not affect an access in progress.
  - If clear coincides with the W_HOLD update, clear wins.
- A request that drops before being granted is simply ignored; no error is reported.

Test Plan:
1. Reset, then rec_req with addr=0x00010, data=0xBEEF, WR_PULSE=2 -> SETUP at cycle 1, we_n low cycles 2-3, ack at cycle 4; dq_oe high cycles 1-4; o_rec_len=0x00011.
2. play_req with addr=0x00010, SRAM model returns 0xBEEF, RD_WAIT=2 -> oe_n low cycles 1-2, o_play_valid=1 with o_play_data=0xBEEF at cycle 3; dq_oe stays 0 throughout.
3. Both reqs high continuously from reset, each re-asserted after its ack/valid -> grants alternate rec, play, rec, play; no gaps besides the single IDLE cycle between accesses.
4. Writes to 0x00005, then 0x00002, then 0xFFFFF -> o_rec_len goes 6, stays 6, then becomes 0x100000; i_clear_len asserted in the same cycle as the last W_HOLD -> o_rec_len=0.
5. i_rst pulsed during W_PULSE -> next cycle we_n=1 and dq_oe=0, no o_rec_ack, state IDLE; a subsequent write completes normally.
6. Sweep WR_PULSE=1,4 and RD_WAIT=1,3 -> ack/valid latency equals WR_PULSE+2 and RD_WAIT+1 respectively.
